// File: rtl/pipe_fetch_decode.sv
// pipe_fetch_decode
//   Fetch/decode/control front end of the pipelined CPU. Holds the PC and the
//   fetch register (instrD), reads a combinational instruction memory, drives
//   the datapath's decode* control inputs, resolves BR and JR, and inserts
//   bubbles for distance-1 RAW hazards, taken branches, JR and HALT.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   imemAdrx / imemData      PC out, instruction in (same cycle)
//   exec{C,N,V,Z}Flag        datapath flags of the slot issued last cycle
//   execRfRdData0Short       rdData0 of the slot issued last cycle (JR target)
//   decode*                  decode-slot controls for the datapath
//   dmemWriteEn              store strobe
//   halted                   high while in HALTED
//
// state   | meaning
// RUN     | fetch and issue normally
// JR_WAIT | JR issued; next cycle PC loads the register value
// HALTED  | bubbles forever, only rst leaves

module pipe_fetch_decode #(
  parameter int unsigned PC_W    = 9,
  parameter logic [2:0]  ALU_ADD = 3'b000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imemAdrx,
  input  logic [31:0]     imemData,
  input  logic            execCFlag,
  input  logic            execNFlag,
  input  logic            execVFlag,
  input  logic            execZFlag,
  input  logic [8:0]      execRfRdData0Short,
  output logic [15:0]     decodeImmediate,
  output logic [4:0]      decodeRfRdAdrx0,
  output logic [4:0]      decodeRfRdAdrx1,
  output logic [4:0]      decodeRfWrAdrx,
  output logic [2:0]      decodeAluCtl,
  output logic            decodeRfWriteEn,
  output logic            decodeAluBusBSel,
  output logic            decodeDmemResultSel,
  output logic            decodeRegDest,
  output logic            dmemWriteEn,
  output logic            halted
);

  localparam logic [5:0]  OP_RTYPE  = 6'd0;
  localparam logic [5:0]  OP_ADDI   = 6'd1;
  localparam logic [5:0]  OP_LW     = 6'd2;
  localparam logic [5:0]  OP_SW     = 6'd3;
  localparam logic [5:0]  OP_BR     = 6'd4;
  localparam logic [5:0]  OP_JR     = 6'd5;
  localparam logic [5:0]  OP_HALT   = 6'd6;
  // Any opcode above 6 decodes as NOP; this is the word loaded on flushes.
  localparam logic [31:0] NOP_INSTR = 32'hFC00_0000;

  typedef enum logic [1:0] {RUN, JR_WAIT, HALTED} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [31:0]     instrD;
  logic [3:0]      savedFlags;  // {C,N,V,Z}
  logic            prevReal;
  logic            prevWrEn;
  logic [4:0]      prevDest;

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic       isReal, readsRs, readsRt, hazard, issueReal, issueJr, brTaken;
  logic [3:0] effFlags;

  assign opcode   = instrD[31:26];
  assign rs       = instrD[25:21];
  assign rt       = instrD[20:16];
  assign rd       = instrD[15:11];
  assign imemAdrx = pc;
  assign halted   = (state == HALTED);

  // Flags of the most recent real instruction survive any run of bubbles.
  assign effFlags = prevReal ? {execCFlag, execNFlag, execVFlag, execZFlag} : savedFlags;

  always_comb begin
    isReal    = (opcode == OP_RTYPE) || (opcode == OP_ADDI) ||
                (opcode == OP_LW)    || (opcode == OP_SW);
    readsRs   = isReal || (opcode == OP_JR);
    readsRt   = (opcode == OP_RTYPE) || (opcode == OP_SW);
    hazard    = (state == RUN) && prevWrEn &&
                ((readsRs && (prevDest == rs)) || (readsRt && (prevDest == rt)));
    issueReal = (state == RUN) && !hazard && isReal;
    issueJr   = (state == RUN) && !hazard && (opcode == OP_JR);
    case (instrD[25:23])
      3'd0:    brTaken = 1'b1;
      3'd1:    brTaken = effFlags[0];
      3'd2:    brTaken = !effFlags[0];
      3'd3:    brTaken = effFlags[2];
      3'd4:    brTaken = !effFlags[2];
      3'd5:    brTaken = effFlags[3];
      3'd6:    brTaken = effFlags[1];
      default: brTaken = 1'b0;
    endcase
  end

  always_comb begin
    decodeImmediate     = 16'd0;
    decodeRfRdAdrx0     = 5'd0;
    decodeRfRdAdrx1     = 5'd0;
    decodeRfWrAdrx      = 5'd0;
    decodeAluCtl        = ALU_ADD;
    decodeRfWriteEn     = 1'b0;
    decodeAluBusBSel    = 1'b0;
    decodeDmemResultSel = 1'b0;
    decodeRegDest       = 1'b0;
    dmemWriteEn         = 1'b0;
    if (issueReal) begin
      decodeImmediate = instrD[15:0];
      decodeRfRdAdrx0 = rs;
      decodeRfRdAdrx1 = rt;
      decodeRfWrAdrx  = rd;
      case (opcode)
        OP_RTYPE: begin
          decodeAluCtl    = instrD[2:0];
          decodeRegDest   = 1'b1;
          decodeRfWriteEn = 1'b1;
        end
        OP_ADDI: begin
          decodeAluBusBSel = 1'b1;
          decodeRfWriteEn  = 1'b1;
        end
        OP_LW: begin
          decodeAluBusBSel    = 1'b1;
          decodeRfWriteEn     = 1'b1;
          decodeDmemResultSel = 1'b1;
        end
        default: begin
          decodeAluBusBSel = 1'b1;
          dmemWriteEn      = 1'b1;
        end
      endcase
    end else if (issueJr) begin
      // rdData0 of this slot comes back as execRfRdData0Short next cycle.
      decodeRfRdAdrx0 = rs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      instrD     <= NOP_INSTR;
      state      <= RUN;
      savedFlags <= 4'd0;
      prevReal   <= 1'b0;
      prevWrEn   <= 1'b0;
      prevDest   <= 5'd0;
    end else begin
      savedFlags <= effFlags;
      prevReal   <= issueReal;
      prevWrEn   <= decodeRfWriteEn;
      prevDest   <= decodeRegDest ? rd : rt;
      case (state)
        RUN: begin
          if (!hazard) begin
            case (opcode)
              OP_JR: begin
                instrD <= NOP_INSTR;
                state  <= JR_WAIT;
              end
              OP_HALT: state <= HALTED;
              OP_BR: begin
                if (brTaken) begin
                  pc     <= instrD[PC_W-1:0];
                  instrD <= NOP_INSTR;
                end else begin
                  pc     <= pc + 1'b1;
                  instrD <= imemData;
                end
              end
              default: begin
                pc     <= pc + 1'b1;
                instrD <= imemData;
              end
            endcase
          end
        end
        JR_WAIT: begin
          pc     <= execRfRdData0Short[PC_W-1:0];
          instrD <= NOP_INSTR;
          state  <= RUN;
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fetch_decode.sv
// Bench for pipe_fetch_decode. A program-order interpreter expands each
// instruction into the decode slots it should occupy and compares the
// resulting per-cycle queue against the DUT.
module tb_pipe_fetch_decode;
  localparam int MAXC = 400;
  localparam logic [31:0] NOPW = 32'hFC00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [8:0]  imemAdrx;
  logic [31:0] imemData;
  logic        execCFlag, execNFlag, execVFlag, execZFlag;
  logic [8:0]  execRfRdData0Short;
  logic [15:0] decodeImmediate;
  logic [4:0]  decodeRfRdAdrx0, decodeRfRdAdrx1, decodeRfWrAdrx;
  logic [2:0]  decodeAluCtl;
  logic        decodeRfWriteEn, decodeAluBusBSel, decodeDmemResultSel, decodeRegDest;
  logic        dmemWriteEn, halted;

  logic [31:0] imem [0:511];
  logic [3:0]  flagsAt [0:MAXC-1];  // {C,N,V,Z} driven during each cycle
  logic [8:0]  rdAt [0:MAXC-1];
  logic [48:0] expQ [$];
  logic [48:0] obs;
  int vectors = 0;
  int miscompares = 0;

  assign imemData = imem[imemAdrx];
  assign obs = {imemAdrx, decodeImmediate, decodeRfRdAdrx0, decodeRfRdAdrx1, decodeRfWrAdrx,
                decodeAluCtl, decodeRfWriteEn, decodeAluBusBSel, decodeDmemResultSel,
                decodeRegDest, dmemWriteEn, halted};

  pipe_fetch_decode dut (
    .clk(clk), .rst(rst), .imemAdrx(imemAdrx), .imemData(imemData),
    .execCFlag(execCFlag), .execNFlag(execNFlag), .execVFlag(execVFlag), .execZFlag(execZFlag),
    .execRfRdData0Short(execRfRdData0Short), .decodeImmediate(decodeImmediate),
    .decodeRfRdAdrx0(decodeRfRdAdrx0), .decodeRfRdAdrx1(decodeRfRdAdrx1),
    .decodeRfWrAdrx(decodeRfWrAdrx), .decodeAluCtl(decodeAluCtl),
    .decodeRfWriteEn(decodeRfWriteEn), .decodeAluBusBSel(decodeAluBusBSel),
    .decodeDmemResultSel(decodeDmemResultSel), .decodeRegDest(decodeRegDest),
    .dmemWriteEn(dmemWriteEn), .halted(halted)
  );

  function automatic logic [31:0] rtype(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t, input logic [2:0] alu);
    return {6'd0, s, t, d, 8'd0, alu};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] t, input logic [4:0] s, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction
  function automatic logic [31:0] br(input logic [2:0] cond, input logic [8:0] tgt);
    return {6'd4, cond, 14'd0, tgt};
  endfunction
  function automatic logic [31:0] jr(input logic [4:0] s);
    return {6'd5, s, 21'd0};
  endfunction

  function automatic logic [48:0] bubble(input logic [8:0] a, input logic h);
    return {a, 16'd0, 15'd0, 3'b000, 5'd0, h};
  endfunction
  function automatic logic [48:0] jrSlot(input logic [8:0] a, input logic [31:0] inst);
    return {a, 16'd0, inst[25:21], 10'd0, 3'b000, 5'd0, 1'b0};
  endfunction
  function automatic logic [48:0] realSlot(input logic [8:0] a, input logic [31:0] inst);
    logic [2:0] alu = 3'b000;
    logic wr = 1'b0, bb = 1'b0, ds = 1'b0, rdSel = 1'b0, we = 1'b0;
    case (inst[31:26])
      6'd0: begin alu = inst[2:0]; wr = 1'b1; rdSel = 1'b1; end
      6'd1: begin wr = 1'b1; bb = 1'b1; end
      6'd2: begin wr = 1'b1; bb = 1'b1; ds = 1'b1; end
      default: begin bb = 1'b1; we = 1'b1; end
    endcase
    return {a, inst[15:0], inst[25:21], inst[20:16], inst[15:11], alu, wr, bb, ds, rdSel, we, 1'b0};
  endfunction

  // Walk the program in issue order and append the slots each instruction occupies.
  task automatic buildExpected(input int n);
    logic [8:0]  addr, nxt;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [3:0]  f;
    logic        lastWr, rdRs, rdRt, taken;
    logic [4:0]  lastDest;
    int          lastReal, c;
    expQ.delete();
    expQ.push_back(bubble(9'd0, 1'b0));
    addr = 9'd0; lastWr = 1'b0; lastDest = 5'd0; lastReal = -1;
    while (expQ.size() < n) begin
      inst = imem[addr];
      op   = inst[31:26];
      nxt  = addr + 9'd1;
      c    = expQ.size();
      rdRs = (op <= 6'd3) || (op == 6'd5);
      rdRt = (op == 6'd0) || (op == 6'd3);
      if (lastWr && ((rdRs && lastDest == inst[25:21]) || (rdRt && lastDest == inst[20:16]))) begin
        expQ.push_back(bubble(nxt, 1'b0));
        lastWr = 1'b0;
        continue;
      end
      if (op <= 6'd3) begin
        expQ.push_back(realSlot(nxt, inst));
        lastWr   = (op != 6'd3);
        lastDest = (op == 6'd0) ? inst[15:11] : inst[20:16];
        lastReal = c;
        addr     = nxt;
      end else if (op == 6'd4) begin
        f = (lastReal < 0) ? 4'd0 : flagsAt[lastReal+1];
        case (inst[25:23])
          3'd0: taken = 1'b1;
          3'd1: taken = f[0];
          3'd2: taken = !f[0];
          3'd3: taken = f[2];
          3'd4: taken = !f[2];
          3'd5: taken = f[3];
          3'd6: taken = f[1];
          default: taken = 1'b0;
        endcase
        expQ.push_back(bubble(nxt, 1'b0));
        lastWr = 1'b0;
        if (taken) begin
          expQ.push_back(bubble(inst[8:0], 1'b0));
          addr = inst[8:0];
        end else addr = nxt;
      end else if (op == 6'd5) begin
        expQ.push_back(jrSlot(nxt, inst));
        expQ.push_back(bubble(nxt, 1'b0));
        expQ.push_back(bubble(rdAt[c+1], 1'b0));
        addr = rdAt[c+1];
        lastWr = 1'b0;
      end else if (op == 6'd6) begin
        expQ.push_back(bubble(nxt, 1'b0));
        while (expQ.size() < n) expQ.push_back(bubble(nxt, 1'b1));
      end else begin
        expQ.push_back(bubble(nxt, 1'b0));
        lastWr = 1'b0;
        addr   = nxt;
      end
    end
  endtask

  task automatic clearProg();
    for (int i = 0; i < 512; i++) imem[i] = NOPW;
    for (int i = 0; i < MAXC; i++) begin flagsAt[i] = 4'd0; rdAt[i] = 9'd0; end
  endtask

  task automatic genRandom(input int haltPct);
    int r;
    for (int i = 0; i < 512; i++) begin
      r = $urandom_range(0, 99);
      if (r < 28)      imem[i] = rtype(5'($urandom_range(0,3)), 5'($urandom_range(0,3)), 5'($urandom_range(0,3)), 3'($urandom));
      else if (r < 43) imem[i] = itype(6'd1, 5'($urandom_range(0,3)), 5'($urandom_range(0,3)), 16'($urandom));
      else if (r < 53) imem[i] = itype(6'd2, 5'($urandom_range(0,3)), 5'($urandom_range(0,3)), 16'($urandom));
      else if (r < 63) imem[i] = itype(6'd3, 5'($urandom_range(0,3)), 5'($urandom_range(0,3)), 16'($urandom));
      else if (r < 78) imem[i] = {6'd4, 3'($urandom), 14'($urandom), 9'($urandom)};
      else if (r < 84) imem[i] = {6'd5, 5'($urandom_range(0,3)), 21'($urandom)};
      else if (r < 84 + haltPct) imem[i] = {6'd6, 26'($urandom)};
      else imem[i] = {6'($urandom_range(7, 63)), 26'($urandom)};
    end
    for (int i = 0; i < MAXC; i++) begin flagsAt[i] = 4'($urandom); rdAt[i] = 9'($urandom); end
  endtask

  task automatic runProg(input int n, input string tag);
    buildExpected(n);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < n; c++) begin
      {execCFlag, execNFlag, execVFlag, execZFlag} = flagsAt[c];
      execRfRdData0Short = rdAt[c];
      @(negedge clk);
      vectors++;
      assert (obs === expQ[c]) else begin
        miscompares++;
        $error("FAIL %s cyc %0d observed %h expected %h", tag, c, obs, expQ[c]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic midReset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk({tag, "_pc"}, 32'(imemAdrx), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_run"}, 32'(imemAdrx), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    {execCFlag, execNFlag, execVFlag, execZFlag} = 4'd0;
    execRfRdData0Short = 9'd0;

    clearProg();
    imem[0] = itype(6'd1, 5'd1, 5'd0, 16'd5);
    imem[1] = itype(6'd1, 5'd2, 5'd0, 16'd7);
    runProg(6, "addi");

    clearProg();
    imem[0] = itype(6'd1, 5'd1, 5'd0, 16'd5);
    imem[1] = rtype(5'd3, 5'd1, 5'd2, 3'd0);
    imem[2] = itype(6'd3, 5'd3, 5'd3, 16'h0010);
    runProg(8, "hazard");

    clearProg();
    imem[0]    = rtype(5'd3, 5'd1, 5'd2, 3'd0);
    imem[1]    = br(3'd1, 9'h040);
    imem[2]    = itype(6'd1, 5'd6, 5'd0, 16'h0222);
    imem[9'h40] = itype(6'd1, 5'd5, 5'd0, 16'h0440);
    for (int i = 0; i < MAXC; i++) flagsAt[i] = 4'b0001;
    runProg(7, "brZ1");
    for (int i = 0; i < MAXC; i++) flagsAt[i] = 4'b0000;
    runProg(7, "brZ0");

    clearProg();
    imem[0]      = itype(6'd1, 5'd1, 5'd0, 16'd1);
    imem[1]      = br(3'd0, 9'h080);
    imem[9'h080] = br(3'd1, 9'h100);
    imem[9'h081] = itype(6'd1, 5'd6, 5'd0, 16'h0666);
    imem[9'h100] = itype(6'd1, 5'd7, 5'd0, 16'h0077);
    flagsAt[2]   = 4'b0001;
    runProg(9, "savedFlags");

    clearProg();
    imem[0] = jr(5'd4);
    imem[9'h123] = itype(6'd2, 5'd2, 5'd4, 16'h0123);
    for (int i = 0; i < MAXC; i++) rdAt[i] = 9'h123;
    runProg(6, "jr");

    clearProg();
    imem[0] = itype(6'd1, 5'd1, 5'd0, 16'd3);
    imem[1] = {6'd6, 26'd0};
    for (int i = 2; i < 40; i++) imem[i] = itype(6'd3, 5'd2, 5'd1, 16'(i));
    runProg(24, "halt");
    chk("haltedHold", 32'(halted), 32'd1);
    midReset("rstHalted");

    clearProg();
    imem[0] = jr(5'd0);
    for (int i = 0; i < MAXC; i++) rdAt[i] = 9'h055;
    runProg(2, "jrPre");
    chk("jrWaitPc", 32'(imemAdrx), 32'd1);
    midReset("rstJrWait");

    for (int k = 0; k < 4; k++) begin
      genRandom((k == 3) ? 1 : 0);
      runProg(250, $sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
